// File: rtl/spike_rate_decoder.sv
// Spike-rate readout: counts spikes per neuron over a window, then forms
// a saturated, weighted Q6.10 average delivered over valid/ready.
module spike_rate_decoder #(
  parameter int N_NEURONS = 10,
  parameter int WINDOW    = 32,
  parameter int W_WIDTH   = 16,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [N_NEURONS-1:0]        spikes_in,
  input  logic                        weight_we,
  input  logic [3:0]                  weight_addr,
  input  logic signed [W_WIDTH-1:0]   weight_data,
  output logic signed [OUT_WIDTH-1:0] y_out,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic                        overflow,
  output logic                        busy
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int SH = $clog2(WINDOW);
  localparam int AW = 32;
  localparam logic signed [AW-1:0] OMAX =
    (2 ** (OUT_WIDTH - 1)) - 1;
  localparam logic signed [AW-1:0] OMIN =
    -(2 ** (OUT_WIDTH - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_SUM,
    S_HOLD
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]              wcnt;
  logic [CW-1:0]              cnt    [N_NEURONS];
  logic signed [W_WIDTH-1:0]  weight [N_NEURONS];
  logic [3:0]                 idx;
  logic signed [AW-1:0]       acc;

  logic clr_cnt;
  logic do_count;
  logic do_acc;
  logic do_done;
  logic hold_exit;
  logic last_samp;
  logic last_idx;

  assign last_samp = (wcnt == CW'(WINDOW - 1));
  assign last_idx  = (idx == 4'(N_NEURONS - 1));
  assign busy = (state == S_COUNT) || (state == S_SUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    clr_cnt   = 1'b0;
    do_count  = 1'b0;
    do_acc    = 1'b0;
    do_done   = 1'b0;
    hold_exit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx = S_COUNT;
          clr_cnt  = 1'b1;
        end
      end
      S_COUNT: begin
        if (enable) begin
          do_count = 1'b1;
          if (last_samp) state_nx = S_SUM;
        end
      end
      S_SUM: begin
        do_acc = 1'b1;
        if (last_idx) begin
          do_done  = 1'b1;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (y_ready) begin
          hold_exit = 1'b1;
          clr_cnt   = 1'b1;
          state_nx  = enable ? S_COUNT : S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  logic [CW-1:0]                cnt_sel;
  logic signed [W_WIDTH-1:0]    w_sel;
  logic signed [AW-1:0]         prod;
  logic signed [AW-1:0]         acc_nx;
  logic signed [AW-1:0]         shifted;
  logic                         sat_hi;
  logic                         sat_lo;
  logic signed [OUT_WIDTH-1:0]  y_res;

  // The final product is folded in combinationally so the result
  // registers on the same edge as the last neuron is consumed.
  always_comb begin
    cnt_sel = cnt[idx];
    w_sel   = weight[idx];
    prod    = $signed({{(AW-CW){1'b0}}, cnt_sel}) *
              $signed({{(AW-W_WIDTH){w_sel[W_WIDTH-1]}}, w_sel});
    acc_nx  = acc + prod;
    shifted = acc_nx >>> SH;
    sat_hi  = (shifted > OMAX);
    sat_lo  = (shifted < OMIN);
    y_res   = shifted[OUT_WIDTH-1:0];
    unique case (1'b1)
      sat_hi:  y_res = OMAX[OUT_WIDTH-1:0];
      sat_lo:  y_res = OMIN[OUT_WIDTH-1:0];
      default: y_res = shifted[OUT_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      idx      <= '0;
      acc      <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        cnt[i]    <= '0;
        weight[i] <= '0;
      end
    end else begin
      if (weight_we &&
          ({1'b0, weight_addr} < 5'(N_NEURONS))) begin
        weight[weight_addr] <= weight_data;
      end
      if (clr_cnt) begin
        wcnt <= '0;
        idx  <= '0;
        acc  <= '0;
        for (int i = 0; i < N_NEURONS; i++) begin
          cnt[i] <= '0;
        end
      end else if (do_count) begin
        wcnt <= wcnt + CW'(1);
        for (int i = 0; i < N_NEURONS; i++) begin
          cnt[i] <= cnt[i] + CW'(spikes_in[i]);
        end
      end
      if (do_acc) begin
        acc <= acc_nx;
        if (!last_idx) idx <= idx + 4'd1;
      end
      if (do_done) begin
        y_out    <= y_res;
        y_valid  <= 1'b1;
        overflow <= overflow | sat_hi | sat_lo;
      end
      if (hold_exit) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed windows plus random traffic,
// all checked each cycle against a window-level arithmetic model.
module tb_spike_rate_decoder;

  localparam int N   = 10;
  localparam int WIN = 32;
  localparam int M_IDLE  = 0;
  localparam int M_COUNT = 1;
  localparam int M_SUM   = 2;
  localparam int M_HOLD  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               enable;
  logic [N-1:0]       spikes_in;
  logic               weight_we;
  logic [3:0]         weight_addr;
  logic signed [15:0] weight_data;
  logic [15:0]        y_out;
  logic               y_valid;
  logic               y_ready;
  logic               overflow;
  logic               busy;

  spike_rate_decoder #(
    .N_NEURONS(N),
    .WINDOW(WIN),
    .W_WIDTH(16),
    .OUT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .spikes_in(spikes_in),
    .weight_we(weight_we),
    .weight_addr(weight_addr),
    .weight_data(weight_data),
    .y_out(y_out),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .overflow(overflow),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  int          m_mode;
  int          m_samp;
  int          m_k;
  int          m_cnt [N];
  int          m_w   [N];
  longint      m_acc;
  logic [15:0] m_y;
  logic        m_valid;
  logic        m_ovf;

  task automatic m_clear();
    m_samp = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic m_finish();
    longint q;
    q = m_acc / WIN;
    if (m_acc < 0 && (m_acc % WIN) != 0) q = q - 1;
    if (q > 32767) begin
      q = 32767;
      m_ovf = 1'b1;
    end else if (q < -32768) begin
      q = -32768;
      m_ovf = 1'b1;
    end
    m_y = q[15:0];
  endtask

  task automatic model_edge();
    if (rst) begin
      m_mode  = M_IDLE;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_y     = '0;
      m_acc   = 0;
      m_clear();
      for (int i = 0; i < N; i++) m_w[i] = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (enable) begin
            m_mode = M_COUNT;
            m_clear();
          end
        end
        M_COUNT: begin
          if (enable) begin
            for (int i = 0; i < N; i++)
              m_cnt[i] += int'(spikes_in[i]);
            m_samp++;
            if (m_samp == WIN) begin
              m_mode = M_SUM;
              m_k = 0;
              m_acc = 0;
            end
          end
        end
        M_SUM: begin
          m_acc += longint'(m_cnt[m_k]) * longint'(m_w[m_k]);
          m_k++;
          if (m_k == N) begin
            m_finish();
            m_valid = 1'b1;
            m_mode = M_HOLD;
          end
        end
        default: begin
          if (y_ready) begin
            m_valid = 1'b0;
            m_mode = enable ? M_COUNT : M_IDLE;
            m_clear();
          end
        end
      endcase
      if (weight_we && int'(weight_addr) < N)
        m_w[weight_addr] = int'(weight_data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("y_valid", y_valid, m_valid);
    chk("busy", busy, (m_mode == M_COUNT || m_mode == M_SUM));
    chk("overflow", overflow, m_ovf);
    chk("y_out", y_out, m_y);
  endtask

  task automatic write_all(input logic [15:0] v);
    for (int i = 0; i < N; i++) begin
      weight_we   = 1'b1;
      weight_addr = 4'(i);
      weight_data = v;
      step();
    end
    weight_we = 1'b0;
  endtask

  logic [N-1:0] sp_base;
  logic         sp_alt;

  task automatic run_until_valid(output int n);
    n = 0;
    while (!y_valid && n < 400) begin
      spikes_in = sp_alt ? (spikes_in ^ sp_base) : sp_base;
      step();
      n++;
    end
    chk("timeout", y_valid, 1'b1);
  endtask

  initial begin
    int n;
    int n2;
    rst = 1'b1;
    enable = 1'b0;
    spikes_in = '0;
    weight_we = 1'b0;
    weight_addr = '0;
    weight_data = '0;
    y_ready = 1'b1;
    sp_base = '0;
    sp_alt = 1'b0;
    m_mode = M_IDLE;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_y = '0;
    m_acc = 0;
    m_k = 0;
    m_clear();
    for (int i = 0; i < N; i++) m_w[i] = 0;
    step();
    step();
    chk("rst_valid", y_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    write_all(16'h0400);
    sp_base = 10'd1;
    spikes_in = sp_base;
    enable = 1'b1;
    step();
    run_until_valid(n);
    chk("c1_lat", n, 42);
    chk("c1_y", y_out, 16'h0400);
    chk("c1_ovf", overflow, 1'b0);
    enable = 1'b0;
    step();

    write_all(16'h0000);
    weight_we = 1'b1;
    weight_addr = 4'd3;
    weight_data = 16'shFC00;
    step();
    weight_we = 1'b0;
    sp_base = 10'b00_0000_1000;
    sp_alt = 1'b1;
    spikes_in = '0;
    enable = 1'b1;
    step();
    run_until_valid(n);
    chk("c2_y", y_out, 16'hFE00);
    sp_alt = 1'b0;
    enable = 1'b0;
    step();

    write_all(16'h7FFF);
    sp_base = '1;
    spikes_in = sp_base;
    enable = 1'b1;
    step();
    run_until_valid(n);
    chk("c3_y", y_out, 16'h7FFF);
    chk("c3_ovf", overflow, 1'b1);
    enable = 1'b0;
    step();
    write_all(16'h0000);
    enable = 1'b1;
    step();
    run_until_valid(n);
    chk("c3b_y", y_out, 16'h0000);
    chk("c3b_ovf", overflow, 1'b1);
    enable = 1'b0;
    step();

    write_all(16'h0400);
    sp_base = 10'd1;
    spikes_in = sp_base;
    enable = 1'b1;
    step();
    run_until_valid(n);
    y_ready = 1'b0;
    spikes_in = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("c4_hold_v", y_valid, 1'b1);
      chk("c4_hold_y", y_out, 16'h0400);
    end
    y_ready = 1'b1;
    step();
    run_until_valid(n);
    chk("c4_lat", n, 42);
    chk("c4_y", y_out, 16'h0400);
    enable = 1'b0;
    step();

    spikes_in = sp_base;
    enable = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) step();
    enable = 1'b1;
    run_until_valid(n2);
    chk("c5_lat", 10 + 8 + n2, 50);
    chk("c5_y", y_out, 16'h0400);
    enable = 1'b0;
    step();

    enable = 1'b1;
    step();
    for (int i = 0; i < 35; i++) step();
    chk("c6_insum", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("c6_valid", y_valid, 1'b0);
    chk("c6_y", y_out, 16'h0000);
    chk("c6_busy", busy, 1'b0);
    sp_base = '1;
    spikes_in = sp_base;
    step();
    run_until_valid(n);
    chk("c6b_y", y_out, 16'h0000);
    enable = 1'b0;
    step();

    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 999) == 0);
      enable = ($urandom_range(0, 9) != 0);
      y_ready = ($urandom_range(0, 3) != 0);
      spikes_in = N'($urandom);
      weight_we = ($urandom_range(0, 7) == 0);
      weight_addr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        weight_data = 16'($urandom);
      else
        weight_data = 16'(int'($urandom_range(0, 4095)) - 2048);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Readout block for the LIF reservoir; inverse direction of the NARMA-value-to-bitstream encoder.
- Counts spikes from N neurons over a fixed window, forms a weighted sum with programmable signed weights, and emits one signed Q6.10 value per window (value = y_out / 1024.0).
- Sits between the neuron `i_out` spike lines and the NARMA error/compare logic.
- Output is delivered with a valid/ready handshake.

Parameters:
- N_NEURONS, 10, number of spike inputs (max 16).
- WINDOW, 32, window length in enabled cycles; must be a power of two, 2..1024.
- W_WIDTH, 16, signed weight width, Q6.10.
- OUT_WIDTH, 16, signed output width, Q6.10.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  counting enable; when low, window progress freezes.
- spikes_in  in  N_NEURONS  one spike bit per neuron per cycle.
- weight_we  in  1  weight write strobe.
- weight_addr  in  4  neuron index; writes with addr >= N_NEURONS are ignored.
- weight_data  in  W_WIDTH  signed Q6.10 weight.
- y_out  out  OUT_WIDTH  signed Q6.10 decoded value.
- y_valid  out  1  y_out holds a result.
- y_ready  in  1  consumer accepts the result.
- overflow  out  1  sticky flag: some result saturated.
- busy  out  1  high in COUNT or SUM.

Behaviour:
- Reset (rst=1 at a clk edge) takes effect at that edge and applies in every state:
  - state = IDLE; y_out = 0; y_valid = 0; overflow = 0; busy = 0.
  - All spike counters, the window counter and the accumulator are cleared.
  - All weights are cleared to 0.
- Weight writes:
  - A write is registered on a clk edge when weight_we=1; weights are readable from the next cycle.
  - Writes are accepted in any state.
  - A write during SUM to an index not yet consumed affects the current result; otherwise it affects the next window.
- FSM states: IDLE, COUNT, SUM, HOLD.
- IDLE:
  - Goes to COUNT on the edge where enable=1.
  - Counters are zeroed on entry to COUNT.
- COUNT:
  - On each edge with enable=1, count[i] += spikes_in[i] for every i, and the window counter increments.
  - Spike counter width is clog2(WINDOW+1); a counter cannot exceed WINDOW, so no saturation is needed.
  - On edges with enable=0, nothing changes; the state is held.
  - After exactly WINDOW enabled samples, goes to SUM.
- SUM:
  - Exactly N_NEURONS cycles, one neuron per cycle, index 0 upward.
  - acc += count[i] * weight[i], using a signed 32-bit accumulator (Q.10).
  - spikes_in is ignored.
- End of SUM:
  - Compute acc >>> log2(WINDOW), an arithmetic shift (floor toward -inf).
  - Saturate to [-32768, 32767].
  - If saturation occurred, set overflow; it stays set until rst.
  - Register the result into y_out, set y_valid = 1, and go to HOLD.
- HOLD:
  - y_out and y_valid are held stable while y_ready = 0.
  - spikes_in is ignored; no spikes are carried into the next window.
  - On the edge with y_ready = 1: y_valid = 0, counters clear, and the next state is COUNT if enable = 1, else IDLE.
  - y_out keeps its last value after y_valid falls.
- Latency:
  - With enable held high and y_ready high, y_valid first rises WINDOW + N_NEURONS edges after the COUNT-entry edge.
  - Window-to-window period is WINDOW + N_NEURONS + 1 cycles.
- enable dropping:
  - During SUM or HOLD, it has no effect on the current result.
  - It only gates COUNT progress and the HOLD exit target.
- y_ready while y_valid = 0 is ignored.

Test Plan:
- All weights 0x0400; spikes_in[0]=1 every cycle, other neurons 0; enable=1, y_ready=1 → after 32+10 cycles y_valid=1, y_out=0x0400 (1.0), overflow=0.
- weight[3]=0xFC00 (-1.0), all other weights 0; neuron 3 spikes on alternate cycles (16 spikes) → y_out=0xFE00 (-0.5).
- All weights 0x7FFF; all 10 neurons spike every cycle → y_out=0x7FFF and overflow=1. Then set weights to 0 and run another window → y_out=0x0000 and overflow remains 1.
- Case 1 stimulus with y_ready held low 5 cycles after y_valid rises → y_out/y_valid stable for 5 cycles; spikes during HOLD do not change the next window's result (next y_out=0x0400).
- Case 1 stimulus with enable=0 for 8 cycles mid-COUNT → y_valid rises 8 cycles later than in case 1; y_out still 0x0400.
- rst asserted for one cycle during SUM → next cycle state IDLE, y_valid=0, y_out=0, busy=0, all weights read 0; a new window with no weight writes yields y_out=0.
